// File: rtl/regfile_psr_pkg.sv
// Shared definitions for the register file / processor status register slice.
//   DATA_W, FLAG_W    : default datapath and flag widths
//   FLAG_*            : bit positions of the flags inside the PSR
//   alu_op_e          : ALU opcodes; flags_mask_for() gives the PSR bits each op updates
package regfile_psr_pkg;

  localparam int DATA_W = 16;
  localparam int FLAG_W = 5;

  localparam int FLAG_C = 0;  // carry
  localparam int FLAG_L = 1;  // unsigned lower
  localparam int FLAG_F = 2;  // signed overflow
  localparam int FLAG_Z = 3;  // zero
  localparam int FLAG_N = 4;  // signed negative / less

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_CMP = 3'd5,
    ALU_MOV = 3'd6,
    ALU_NOP = 3'd7
  } alu_op_e;

  // Arithmetic ops update every flag; logic ops and moves only Z and N.
  function automatic logic [FLAG_W-1:0] flags_mask_for(input alu_op_e op);
    logic [FLAG_W-1:0] m;
    m = '0;
    case (op)
      ALU_ADD, ALU_SUB, ALU_CMP: m = '1;
      ALU_AND, ALU_OR, ALU_XOR, ALU_MOV: begin
        m[FLAG_Z] = 1'b1;
        m[FLAG_N] = 1'b1;
      end
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/regfile_psr_psr.sv
// psr_reg: processor status register with per-bit update enables.
//   clk, reset  : rising-edge clock, asynchronous active-high clear
//   flags_in    : new flag values from the ALU
//   flags_mask  : per-bit load enable (0 holds the bit)
//   flags_out   : registered PSR contents, no bypass
module psr_reg #(
  parameter int FLAG_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic [FLAG_W-1:0] flags_mask,
  output logic [FLAG_W-1:0] flags_out
);

  import regfile_psr_pkg::*;

  logic [FLAG_W-1:0] psr_d;
  logic [FLAG_W-1:0] psr_q;

  always_comb begin
    psr_d = (psr_q & ~flags_mask) | (flags_in & flags_mask);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) psr_q <= '0;
    else       psr_q <= psr_d;
  end

  assign flags_out = psr_q;

endmodule

// File: rtl/regfile_psr.sv
// regfile_psr: general register file with two combinational read ports,
// one write port with write-through bypass, and a masked PSR.
//   clk, reset            : rising-edge clock, asynchronous active-high clear
//   rd_addr_a/b, rd_data_a/b : ALU operand read ports (same-cycle)
//   wr_en, wr_addr, wr_data  : ALU result write port
//   flags_in, flags_mask     : ALU flags and per-bit PSR update enable
//   flags_out                : registered PSR
module regfile_psr #(
  parameter int DATA_W = regfile_psr_pkg::DATA_W,
  parameter int NREGS  = 16,
  parameter int FLAG_W = regfile_psr_pkg::FLAG_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [$clog2(NREGS)-1:0] rd_addr_a,
  input  logic [$clog2(NREGS)-1:0] rd_addr_b,
  output logic [DATA_W-1:0]        rd_data_a,
  output logic [DATA_W-1:0]        rd_data_b,
  input  logic                     wr_en,
  input  logic [$clog2(NREGS)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [FLAG_W-1:0]        flags_in,
  input  logic [FLAG_W-1:0]        flags_mask,
  output logic [FLAG_W-1:0]        flags_out
);

  import regfile_psr_pkg::*;

  logic [DATA_W-1:0] regs_d [NREGS];
  logic [DATA_W-1:0] regs_q [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Write-through: a read of the register being written sees the new value now.
  always_comb begin
    rd_data_a = regs_q[rd_addr_a];
    rd_data_b = regs_q[rd_addr_b];
    if (wr_en && (wr_addr == rd_addr_a)) rd_data_a = wr_data;
    if (wr_en && (wr_addr == rd_addr_b)) rd_data_b = wr_data;
  end

  psr_reg #(
    .FLAG_W(FLAG_W)
  ) u_psr (
    .clk       (clk),
    .reset     (reset),
    .flags_in  (flags_in),
    .flags_mask(flags_mask),
    .flags_out (flags_out)
  );

endmodule

// File: tb/tb_regfile_psr.sv
// Scoreboard bench for regfile_psr: stimulus drives one vector per cycle and
// queues the expected read/flag outputs from an array model; a monitor on the
// falling edge pops and compares.
module tb_regfile_psr;

  import regfile_psr_pkg::*;

  logic        clk;
  logic        reset;
  logic [3:0]  rd_addr_a, rd_addr_b, wr_addr;
  logic [15:0] rd_data_a, rd_data_b, wr_data;
  logic        wr_en;
  logic [4:0]  flags_in, flags_mask, flags_out;

  regfile_psr #(
    .DATA_W(16),
    .NREGS (16),
    .FLAG_W(5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .flags_in  (flags_in),
    .flags_mask(flags_mask),
    .flags_out (flags_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [4:0]  f;
    int          id;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] mem [16];
  logic [4:0]  psr;
  int          checks = 0;
  int          errors = 0;
  int          step_id = 0;

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    psr = 5'b00000;
  endtask

  // One clock cycle: drive, predict, advance the model at the edge.
  task automatic step(input logic rst, input logic we, input logic [3:0] wa,
                      input logic [15:0] wd, input logic [3:0] ra, input logic [3:0] rb,
                      input logic [4:0] fi, input logic [4:0] fm);
    exp_t e;
    reset = rst; wr_en = we; wr_addr = wa; wr_data = wd;
    rd_addr_a = ra; rd_addr_b = rb; flags_in = fi; flags_mask = fm;
    if (rst) model_clear();
    e.a  = (we && wa == ra) ? wd : mem[ra];
    e.b  = (we && wa == rb) ? wd : mem[rb];
    e.f  = psr;
    e.id = step_id;
    sb_q.push_back(e);
    step_id++;
    @(posedge clk);
    if (!rst) begin
      if (we) mem[wa] = wd;
      for (int i = 0; i < 5; i++) if (fm[i]) psr[i] = fi[i];
    end
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (rd_data_a !== e.a) begin
        errors++;
        $display("FAIL rd_data_a step %0d got %h want %h", e.id, rd_data_a, e.a);
      end
      checks++;
      if (rd_data_b !== e.b) begin
        errors++;
        $display("FAIL rd_data_b step %0d got %h want %h", e.id, rd_data_b, e.b);
      end
      checks++;
      if (flags_out !== e.f) begin
        errors++;
        $display("FAIL flags_out step %0d got %b want %b", e.id, flags_out, e.f);
      end
    end
  end

  initial begin
    logic [3:0]  wa, ra, rb;
    logic [15:0] wd;
    logic [4:0]  fm;
    logic        we, rst;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr_a = '0; rd_addr_b = '0; flags_in = '0; flags_mask = '0;
    model_clear();
    @(posedge clk); #1;

    // Reset held: every index reads zero, PSR zero.
    for (int i = 0; i < 16; i++)
      step(1'b1, 1'b0, 4'd0, 16'h0, 4'(i), 4'(15 - i), 5'b00000, 5'b00000);

    // r3 write with same-cycle bypass, then registered read.
    step(1'b0, 1'b1, 4'd3, 16'h1234, 4'd3, 4'd3, 5'b0, 5'b0);
    step(1'b0, 1'b0, 4'd0, 16'h0, 4'd3, 4'd3, 5'b0, 5'b0);

    // PSR masked update.
    step(1'b0, 1'b0, 4'd0, 16'h0, 4'd0, 4'd1, 5'b11111, 5'b01010);
    step(1'b0, 1'b0, 4'd0, 16'h0, 4'd0, 4'd1, 5'b00000, 5'b00001);
    step(1'b0, 1'b0, 4'd0, 16'h0, 4'd0, 4'd1, 5'b00000, 5'b00000);

    // r15 and r0 in consecutive cycles, then full sweep.
    step(1'b0, 1'b1, 4'd15, 16'hFFFF, 4'd1, 4'd2, 5'b0, 5'b0);
    step(1'b0, 1'b1, 4'd0, 16'h0001, 4'd1, 4'd2, 5'b0, 5'b0);
    for (int i = 0; i < 16; i++)
      step(1'b0, 1'b0, 4'd0, 16'h0, 4'(i), 4'(15 - i), 5'b0, 5'b0);

    // Disabled write leaves r5 and does not bypass.
    step(1'b0, 1'b1, 4'd5, 16'h5555, 4'd0, 4'd0, 5'b0, 5'b0);
    step(1'b0, 1'b0, 4'd5, 16'hAAAA, 4'd5, 4'd5, 5'b0, 5'b0);
    step(1'b0, 1'b0, 4'd5, 16'hAAAA, 4'd5, 4'd5, 5'b0, 5'b0);

    // r7 written, then asynchronous reset mid-cycle; write during reset lost.
    step(1'b0, 1'b1, 4'd7, 16'hBEEF, 4'd7, 4'd0, 5'b10101, 5'b11111);
    step(1'b1, 1'b0, 4'd0, 16'h0, 4'd7, 4'd0, 5'b11111, 5'b11111);
    step(1'b1, 1'b1, 4'd7, 16'hCAFE, 4'd3, 4'd7, 5'b11111, 5'b11111);
    step(1'b0, 1'b0, 4'd0, 16'h0, 4'd7, 4'd3, 5'b0, 5'b0);
    step(1'b0, 1'b1, 4'd7, 16'h0BAD, 4'd0, 4'd0, 5'b0, 5'b0);
    step(1'b0, 1'b0, 4'd0, 16'h0, 4'd7, 4'd7, 5'b0, 5'b0);

    // Randomized traffic; reads biased toward the write address to exercise bypass.
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      we  = ($urandom_range(0, 3) != 0);
      wa  = 4'($urandom_range(0, 15));
      wd  = 16'($urandom);
      ra  = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
      rb  = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
      fm  = ($urandom_range(0, 1) == 1) ? flags_mask_for(alu_op_e'($urandom_range(0, 7)))
                                        : 5'($urandom);
      step(rst, we, wa, wd, ra, rb, 5'($urandom), fm);
    end

    @(negedge clk); #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
